// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg: definitions shared by the control FSM, alucontrol and the
// datapath benches: opcode constants, ALUOp class codes, FSM state encoding,
// the bundle of datapath control lines and a small opcode helper.
package control_fsm_pkg;

  // Instruction[31:26] opcodes understood by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALUOp class codes handed to alucontrol
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MEM  = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = 9'b0_0000_0000;

  // True for the opcodes that need a data-memory access
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/control_fsm_wait_timer.sv
// wait_timer: counts cycles spent waiting for a memory acknowledge.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous clear to zero (has priority over enable)
//   enable : count up by one this cycle
//   tc     : high while the count is LIMIT-1, i.e. the increment taken in
//            this cycle makes the count reach LIMIT
module wait_timer #(
  parameter int LIMIT = 15,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [W-1:0] cnt_r;

  // Wait-cycle counter with synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == W'(LIMIT - 1));

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle controller for a small MIPS-like datapath.
//   clk, reset (async, active-low)
//   OpCode       : Instruction[31:26]
//   mem_ack      : data memory finished the current load/store
//   RegDst..Branch, ALUOp : datapath controls (Mealy decode in EXEC)
//   pc_en        : instruction retires / PC advances at this edge
//   fault        : sticky halt flag, registered
//   instr_count  : wrapping count of retired instructions
// Load/store instructions wait in MEM for mem_ack; a missing ack for
// MEM_TIMEOUT wait cycles, or an unknown opcode, parks the block in HALT
// until reset.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OpCode,
  input  logic             mem_ack,
  output logic             RegDst,
  output logic             AluSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic [1:0]       ALUOp,
  output logic             pc_en,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           next_state_s;
  logic [5:0]       op_latched_r;
  logic             fault_r;
  logic [CNT_W-1:0] count_r;
  ctrl_t            ctrl_s;
  logic             pc_en_s;
  logic             wait_clr_s;
  logic             wait_en_s;
  logic             wait_tc_s;

  wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (wait_clr_s),
    .enable (wait_en_s),
    .tc     (wait_tc_s)
  );

  // Next state, control decode and wait-timer control.
  always_comb begin
    ctrl_s       = CTRL_NONE;
    pc_en_s      = 1'b0;
    next_state_s = state_r;
    // Timer is held at zero outside MEM so it starts from 0 on every entry.
    wait_clr_s   = (state_r != ST_MEM);
    wait_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        next_state_s = ST_EXEC;
      end
      ST_EXEC: begin
        case (OpCode)
          OP_RTYPE: begin
            ctrl_s.reg_dst   = 1'b1;
            ctrl_s.reg_write = 1'b1;
            ctrl_s.alu_op    = ALUOP_FUNCT;
            pc_en_s          = 1'b1;
          end
          OP_ADDI: begin
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.reg_write = 1'b1;
            ctrl_s.alu_op    = ALUOP_ADD;
            pc_en_s          = 1'b1;
          end
          OP_BEQ: begin
            ctrl_s.branch = 1'b1;
            ctrl_s.alu_op = ALUOP_SUB;
            pc_en_s       = 1'b1;
          end
          OP_LW: begin
            ctrl_s.alu_src  = 1'b1;
            ctrl_s.mem_read = 1'b1;
            ctrl_s.alu_op   = ALUOP_ADD;
            next_state_s    = ST_MEM;
          end
          OP_SW: begin
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.mem_write = 1'b1;
            ctrl_s.alu_op    = ALUOP_ADD;
            next_state_s     = ST_MEM;
          end
          default: begin
            next_state_s = ST_HALT;
          end
        endcase
      end
      ST_MEM: begin
        // Controls come from the latched opcode; OpCode is not looked at.
        ctrl_s.alu_src = 1'b1;
        ctrl_s.alu_op  = ALUOP_ADD;
        if (op_latched_r == OP_LW) begin
          ctrl_s.mem_read = 1'b1;
        end else begin
          ctrl_s.mem_write = 1'b1;
        end
        if (mem_ack) begin
          // Ack beats a simultaneous timeout.
          pc_en_s      = 1'b1;
          next_state_s = ST_EXEC;
          if (op_latched_r == OP_LW) begin
            ctrl_s.mem_to_reg = 1'b1;
            ctrl_s.reg_write  = 1'b1;
          end else begin
            ctrl_s.mem_to_reg = 1'b0;
            ctrl_s.reg_write  = 1'b0;
          end
        end else begin
          wait_en_s = 1'b1;
          if (wait_tc_s) begin
            next_state_s = ST_HALT;
          end else begin
            next_state_s = ST_MEM;
          end
        end
      end
      ST_HALT: begin
        next_state_s = ST_HALT;
      end
      default: begin
        next_state_s = ST_HALT;
      end
    endcase
  end

  // State, latched load/store opcode, sticky fault and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      op_latched_r <= 6'b000000;
      fault_r      <= 1'b0;
      count_r      <= '0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == ST_EXEC) && is_mem_op(OpCode)) begin
        op_latched_r <= OpCode;
      end else begin
        op_latched_r <= op_latched_r;
      end
      // Set on the edge that enters HALT, so it is visible in the first HALT cycle.
      if (next_state_s == ST_HALT) begin
        fault_r <= 1'b1;
      end else begin
        fault_r <= fault_r;
      end
      if (pc_en_s) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign RegDst      = ctrl_s.reg_dst;
  assign AluSrc      = ctrl_s.alu_src;
  assign MemtoReg    = ctrl_s.mem_to_reg;
  assign RegWrite    = ctrl_s.reg_write;
  assign MemRead     = ctrl_s.mem_read;
  assign MemWrite    = ctrl_s.mem_write;
  assign Branch      = ctrl_s.branch;
  assign ALUOp       = ctrl_s.alu_op;
  assign pc_en       = pc_en_s;
  assign fault       = fault_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed scenarios with hand-computed expectations plus a
// randomized run, all checked every cycle against a behavioural model that
// tracks "idle cycle done / halted / pending memory access + cycles waited".
// Control vector layout: {RegDst, AluSrc, MemtoReg, RegWrite, MemRead,
// MemWrite, Branch, ALUOp[1:0], pc_en}.
module tb_control_fsm;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [5:0]       OpCode = 6'b000000;
  logic             mem_ack = 1'b0;
  logic             RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0]       ALUOp;
  logic             pc_en, fault;
  logic [CNT_W-1:0] instr_count;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b1;

  // behavioural model state
  bit m_idle_done = 1'b0;
  bit m_halted    = 1'b0;
  bit m_pend      = 1'b0;
  bit m_pend_load = 1'b0;
  int m_waited    = 0;
  int m_cnt       = 0;
  logic [9:0] m_e;

  control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .mem_ack(mem_ack),
    .RegDst(RegDst), .AluSrc(AluSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
    .pc_en(pc_en), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected controls from the instruction-set rules for the current situation.
  function automatic logic [9:0] exp_ctl(input logic [5:0] op, input logic ack);
    if (!reset || !m_idle_done || m_halted) return 10'b0000000000;
    if (m_pend) begin
      if (m_pend_load) return ack ? 10'b0111100001 : 10'b0100100000;
      else             return ack ? 10'b0100010001 : 10'b0100010000;
    end
    case (op)
      6'b000000: return 10'b1001000101;  // R-type
      6'b001000: return 10'b0101000001;  // addi
      6'b000100: return 10'b0000001011;  // beq
      6'b100011: return 10'b0100100000;  // lw issue
      6'b101011: return 10'b0100010000;  // sw issue
      default:   return 10'b0000000000;
    endcase
  endfunction

  // Model advance at each clock edge; cleared by reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_idle_done = 1'b0; m_halted = 1'b0; m_pend = 1'b0; m_pend_load = 1'b0;
      m_waited = 0; m_cnt = 0;
    end else begin
      m_e = exp_ctl(OpCode, mem_ack);
      if (m_e[0]) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (!m_idle_done) begin
        m_idle_done = 1'b1;
      end else if (m_halted) begin
        m_halted = 1'b1;
      end else if (m_pend) begin
        if (mem_ack) begin
          m_pend = 1'b0;
        end else begin
          m_waited++;
          if (m_waited == MEM_TIMEOUT) begin
            m_halted = 1'b1;
            m_pend = 1'b0;
          end
        end
      end else begin
        case (OpCode)
          6'b100011: begin m_pend = 1'b1; m_pend_load = 1'b1; m_waited = 0; end
          6'b101011: begin m_pend = 1'b1; m_pend_load = 1'b0; m_waited = 0; end
          6'b000000, 6'b001000, 6'b000100: m_waited = 0;
          default: m_halted = 1'b1;
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("cycle_ctl", {22'd0, RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                          Branch, ALUOp, pc_en}, {22'd0, exp_ctl(OpCode, mem_ack)});
      check("cycle_fault", {31'd0, fault}, {31'd0, m_halted});
      check("cycle_count", {16'd0, instr_count}, m_cnt);
    end
  end

  // One cycle: drive, sample mid-cycle, return just after the next rising edge.
  task automatic cycle(input logic [5:0] op, input logic ack,
                       output logic [9:0] ctl, output logic flt);
    OpCode = op;
    mem_ack = ack;
    @(negedge clk);
    ctl = {RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, pc_en};
    flt = fault;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ack = 1'b0;
    OpCode = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic [9:0] c;
  logic       f;
  int         n_a, n_b, hc, r;
  logic [5:0] op;

  initial begin
    // reset state
    @(negedge clk);
    check("reset_ctl", {22'd0, RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                        Branch, ALUOp, pc_en}, 32'd0);
    check("reset_fault", {31'd0, fault}, 32'd0);
    check("reset_count", {16'd0, instr_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // idle cycle, then three R-type retires
    cycle(6'b000000, 1'b0, c, f);
    check("idle_ctl", {22'd0, c}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(6'b000000, 1'b0, c, f);
      check("rtype_ctl", {22'd0, c}, {22'd0, 10'b1001000101});
    end
    check("rtype_count", {16'd0, instr_count}, 32'd3);

    // lw, ack in the fifth cycle; garbage OpCode while waiting must be ignored
    n_a = 0; n_b = 0;
    for (int i = 0; i < 5; i++) begin
      cycle((i == 0) ? 6'b100011 : 6'b111111, (i == 4), c, f);
      if (c[5]) n_a++;
      if (!c[0]) n_b++;
      if (i == 4) check("lw_ack_ctl", {22'd0, c}, {22'd0, 10'b0111100001});
    end
    check("lw_memread_cycles", n_a, 32'd5);
    check("lw_pc_en0_cycles", n_b, 32'd4);
    check("lw_count", {16'd0, instr_count}, 32'd4);

    // sw never acknowledged: decode cycle plus 15 wait cycles, then HALT
    n_a = 0; n_b = 0;
    for (int i = 0; i < 16; i++) begin
      cycle((i == 0) ? 6'b101011 : 6'b000000, 1'b0, c, f);
      if (c[4]) n_a++;
      if (c[0]) n_b++;
    end
    check("sw_to_memwrite_cycles", n_a, 32'd16);
    check("sw_to_fault_before", {31'd0, f}, 32'd0);
    cycle(6'b000000, 1'b0, c, f);
    check("sw_to_fault", {31'd0, f}, 32'd1);
    check("sw_to_halt_ctl", {22'd0, c}, 32'd0);
    check("sw_to_pc_en_cycles", n_b, 32'd0);
    check("sw_to_count", {16'd0, instr_count}, 32'd4);

    // sw with ack exactly in the timeout cycle: ack wins
    do_reset();
    cycle(6'b000000, 1'b0, c, f);
    cycle(6'b101011, 1'b0, c, f);
    for (int i = 0; i < 14; i++) cycle(6'b000000, 1'b0, c, f);
    cycle(6'b000000, 1'b1, c, f);
    check("sw_edge_ack_ctl", {22'd0, c}, {22'd0, 10'b0100010001});
    cycle(6'b000000, 1'b0, c, f);
    check("sw_edge_fault", {31'd0, f}, 32'd0);
    check("sw_edge_next_ctl", {22'd0, c}, {22'd0, 10'b1001000101});
    check("sw_edge_count", {16'd0, instr_count}, 32'd2);

    // illegal opcode halts; later valid opcodes are ignored
    cycle(6'b111111, 1'b0, c, f);
    check("illegal_ctl", {22'd0, c}, 32'd0);
    cycle(6'b000000, 1'b0, c, f);
    check("illegal_ctl_after", {22'd0, c}, 32'd0);
    check("illegal_fault", {31'd0, f}, 32'd1);
    cycle(6'b001000, 1'b0, c, f);
    check("illegal_addi_ignored", {22'd0, c}, 32'd0);
    check("illegal_count", {16'd0, instr_count}, 32'd2);

    // reset asserted in the middle of a MEM wait
    do_reset();
    cycle(6'b000000, 1'b0, c, f);
    cycle(6'b000000, 1'b0, c, f);
    cycle(6'b100011, 1'b0, c, f);
    cycle(6'b000000, 1'b0, c, f);
    #1;
    check("midmem_memread", {31'd0, MemRead}, 32'd1);
    reset = 1'b0;
    #1;
    check("midmem_reset_ctl", {22'd0, RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                               Branch, ALUOp, pc_en}, 32'd0);
    check("midmem_reset_count", {16'd0, instr_count}, 32'd0);
    check("midmem_reset_fault", {31'd0, fault}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // counter wrap
    cycle(6'b000000, 1'b0, c, f);
    for (int i = 0; i < 65535; i++) cycle(6'b000000, 1'b0, c, f);
    check("wrap_ffff", {16'd0, instr_count}, 32'h0000FFFF);
    cycle(6'b000000, 1'b0, c, f);
    check("wrap_zero", {16'd0, instr_count}, 32'd0);

    // randomized traffic
    hc = 0;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 25)      op = 6'b000000;
      else if (r < 40) op = 6'b001000;
      else if (r < 50) op = 6'b000100;
      else if (r < 65) op = 6'b100011;
      else if (r < 80) op = 6'b101011;
      else if (r < 83) op = 6'($urandom_range(0, 63));
      else             op = 6'b000000;
      cycle(op, ($urandom_range(0, 4) == 0), c, f);
      if (m_halted) hc++;
      else hc = 0;
      if (hc > 3 || $urandom_range(0, 299) == 0) begin
        do_reset();
        hc = 0;
      end
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum number of cycles spent waiting for mem_ack before a fault.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port OpCode, input, 6 bits: Instruction[31:26] from the datapath.
REQ-006 SHALL have port mem_ack, input, 1 bit: data memory done for the current load/store.
REQ-007 SHALL have ports RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite and Branch, each an output of 1 bit, driving the datapath controls of the same names.
REQ-008 SHALL have port ALUOp, output, 2 bits: class code to alucontrol.
REQ-009 SHALL have port pc_en, output, 1 bit: PC may advance at this edge; the instruction retires.
REQ-010 SHALL have port fault, output, 1 bit: sticky halt indication.
REQ-011 SHALL have port instr_count, output, CNT_W bits: count of retired instructions.

Function
REQ-012 SHALL implement the states IDLE, EXEC, MEM and HALT.
REQ-013 IDLE SHALL last exactly one cycle after reset release, with all controls and pc_en at 0, then go to EXEC.
REQ-014 In EXEC, the controls SHALL be a combinational decode of OpCode (Mealy), as follows:
- R-type 000000: RegDst=1, RegWrite=1, ALUOp=10, pc_en=1, stay in EXEC.
- addi 001000: AluSrc=1, RegWrite=1, ALUOp=00, pc_en=1, stay in EXEC.
- beq 000100: Branch=1, ALUOp=01, pc_en=1, stay in EXEC.
- lw 100011 and sw 101011: AluSrc=1, ALUOp=00, MemRead (lw) or MemWrite (sw)=1, pc_en=0, go to MEM.
- Any other OpCode: all controls 0, pc_en=0, go to HALT.
REQ-015 Controls not listed for an opcode SHALL be 0.
REQ-016 In MEM, AluSrc, ALUOp=00 and MemRead/MemWrite SHALL be held for the latched opcode, and pc_en SHALL be 0 while mem_ack=0; a repeated store is idempotent because the PC is frozen.
REQ-017 When mem_ack=1 in MEM, the block SHALL assert pc_en=1 in the same cycle (plus MemtoReg=1 and RegWrite=1 for lw) and return to EXEC.
REQ-018 The load/store opcode SHALL be latched on entry to MEM, and OpCode SHALL be ignored while in MEM.
REQ-019 A wait counter SHALL clear on entry to MEM and increment each MEM cycle with mem_ack=0.
REQ-020 When the wait counter reaches MEM_TIMEOUT with mem_ack=0, the block SHALL go to HALT; if mem_ack=1 arrives in that same cycle, the ack SHALL win and the instruction retires.
REQ-021 mem_ack asserted outside MEM SHALL be ignored.
REQ-022 In HALT, all controls and pc_en SHALL be 0 and fault SHALL be 1, and the block SHALL leave HALT only on reset.
REQ-023 instr_count SHALL increment by 1 on every edge where pc_en=1 and wrap from all-ones to 0.
REQ-024 fault SHALL be registered: it rises the cycle after HALT is entered.

Reset
REQ-025 reset=0 SHALL immediately, without a clock, force state IDLE, wait counter 0, instr_count 0, fault 0, latched opcode 0, and all outputs to 0.
REQ-026 Reset asserted mid-MEM SHALL abort the access with no retire and no RegWrite.
REQ-027 After reset release, the first decode SHALL occur in the second cycle.

Structure
REQ-028 The opcode constants (R-type, lw, sw, beq, addi), the ALUOp codes and the state encoding SHALL reside in a shared package, also used by the alucontrol and datapath benches.
REQ-029 A separate sub-module SHALL NOT be used for decode; the wait counter MAY be the sub-module wait_timer (clear, enable, terminal-count output).

Verification
REQ-030 SHALL cover: reset low, release, then OpCode=000000 for 3 cycles -> 1 idle cycle, then pc_en=1 and RegWrite=1 with RegDst=1 on each cycle; instr_count=3.
REQ-031 SHALL cover: lw with mem_ack delayed 4 cycles -> MemRead=1 for 5 cycles, pc_en=0 for 4, then pc_en=1 with MemtoReg=1 and RegWrite=1 on the ack cycle; instr_count +1.
REQ-032 SHALL cover: sw with mem_ack never asserted -> MemWrite held 15 cycles, then HALT; fault=1 next cycle; pc_en stays 0.
REQ-033 SHALL cover: sw with mem_ack rising exactly at the timeout cycle -> retire, no fault.
REQ-034 SHALL cover: OpCode=111111 in EXEC -> all outputs 0 and fault=1; a later valid OpCode gives no response until reset.
REQ-035 SHALL cover: instr_count preset near 16'hFFFF via 65535 R-type retires, then 1 more -> wraps to 0; also reset asserted mid-MEM -> all outputs 0 asynchronously.
